ca_item_memory_sequencer: RTL and testbench

- Sequences the rule-30 cellular automaton hypervector generator so it acts as an addressable item memory.
- Item k is defined as the CA state after k steps from `CELLULAR_AUTOMATON_SEED`; item 0 is the seed itself.
- Accepts a channel-index request, drives the CA Clear/Enable controls, captures the resulting state and returns it over a valid/ready handshake.
- Sits directly downstream of the CA, in front of the spatial encoder.

---
 rtl/ca_item_memory_sequencer.sv | 104 ++++++++++
 tb/tb_ca_item_memory_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ca_item_memory_sequencer.sv
// ca_item_memory_sequencer: turns the rule-30 CA into an addressable item memory via Clear/Enable sequencing
`ifndef HV_DIMENSION
`define HV_DIMENSION 2048
`endif

module ca_item_memory_sequencer #(
  parameter int WIDTH     = `HV_DIMENSION,
  parameter int NUM_ITEMS = 64,
  parameter int IDX_WIDTH = $clog2(NUM_ITEMS)
) (
  input  logic                 Clk_CI,
  input  logic                 Reset_RI,
  input  logic                 ReqValid_SI,
  output logic                 ReqReady_SO,
  input  logic [IDX_WIDTH:0]   ReqIdx_DI,
  output logic                 CaClear_SO,
  output logic                 CaEnable_SO,
  input  logic [WIDTH-1:0]     CaValue_DI,
  output logic                 HvValid_SO,
  input  logic                 HvReady_SI,
  output logic [WIDTH-1:0]     Hv_DO,
  output logic                 Err_SO
);

  typedef enum logic [2:0] {IDLE, CLEAR, STEP, CAPTURE, OUT} state_t;

  localparam logic [IDX_WIDTH:0] LIMIT = (IDX_WIDTH+1)'(NUM_ITEMS);

  state_t               state;
  logic [IDX_WIDTH-1:0] pos;
  logic [IDX_WIDTH:0]   tgt;
  logic [IDX_WIDTH:0]   pos_x;
  logic [IDX_WIDTH:0]   pos_n;

  // widened position so it compares directly against the index, which carries a range bit
  always_comb begin
    pos_x = {1'b0, pos};
    pos_n = pos_x + (IDX_WIDTH+1)'(1);
  end

  assign ReqReady_SO = (state == IDLE) && !Reset_RI;

  // sequencer FSM: decides clear/step/hit per request, CA controls registered alongside the state
  always_ff @(posedge Clk_CI) begin
    if (Reset_RI) begin
      state       <= IDLE;
      pos         <= '0;
      tgt         <= '0;
      HvValid_SO  <= 1'b0;
      Err_SO      <= 1'b0;
      CaClear_SO  <= 1'b0;
      CaEnable_SO <= 1'b0;
      Hv_DO       <= '0;
    end else begin
      case (state)
        IDLE: if (ReqValid_SI) begin
          tgt <= ReqIdx_DI;
          if (ReqIdx_DI >= LIMIT) begin
            state      <= OUT;
            Err_SO     <= 1'b1;
            Hv_DO      <= '0;
            HvValid_SO <= 1'b1;
          end else if (ReqIdx_DI == pos_x) begin
            state <= CAPTURE;
          end else if (ReqIdx_DI > pos_x) begin
            state       <= STEP;
            CaEnable_SO <= 1'b1;
          end else begin
            state      <= CLEAR;
            CaClear_SO <= 1'b1;
          end
        end
        CLEAR: begin
          CaClear_SO <= 1'b0;
          pos        <= '0;
          if (tgt == '0) state <= CAPTURE;
          else begin
            state       <= STEP;
            CaEnable_SO <= 1'b1;
          end
        end
        STEP: begin
          pos <= pos + IDX_WIDTH'(1);
          if (pos_n == tgt) begin
            state       <= CAPTURE;
            CaEnable_SO <= 1'b0;
          end
        end
        CAPTURE: begin
          Hv_DO      <= CaValue_DI;
          Err_SO     <= 1'b0;
          HvValid_SO <= 1'b1;
          state      <= OUT;
        end
        OUT: if (HvReady_SI) begin
          HvValid_SO <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_item_memory_sequencer.sv
// tb_ca_item_memory_sequencer: table-driven check of the item memory sequencer against a rule-30 CA model
module tb_ca_item_memory_sequencer;

  localparam int W  = 64;
  localparam int N  = 64;
  localparam int IW = 6;
  localparam logic [W-1:0] SEED = 64'h8000_0000_0001_2345;

  logic          Clk_CI = 1'b0;
  logic          Reset_RI = 1'b1;
  logic          ReqValid_SI = 1'b0;
  logic          ReqReady_SO;
  logic [IW:0]   ReqIdx_DI = '0;
  logic          CaClear_SO;
  logic          CaEnable_SO;
  logic [W-1:0]  CaValue_DI;
  logic          HvValid_SO;
  logic          HvReady_SI = 1'b1;
  logic [W-1:0]  Hv_DO;
  logic          Err_SO;

  int checks = 0;
  int errors = 0;

  ca_item_memory_sequencer #(.WIDTH(W), .NUM_ITEMS(N)) dut (
    .Clk_CI(Clk_CI), .Reset_RI(Reset_RI), .ReqValid_SI(ReqValid_SI), .ReqReady_SO(ReqReady_SO),
    .ReqIdx_DI(ReqIdx_DI), .CaClear_SO(CaClear_SO), .CaEnable_SO(CaEnable_SO), .CaValue_DI(CaValue_DI),
    .HvValid_SO(HvValid_SO), .HvReady_SI(HvReady_SI), .Hv_DO(Hv_DO), .Err_SO(Err_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  function automatic logic [W-1:0] rule30(input logic [W-1:0] s);
    logic [W-1:0] n;
    for (int i = 0; i < W; i++) n[i] = s[(i+1)%W] ^ (s[i] | s[(i+W-1)%W]);
    return n;
  endfunction

  function automatic logic [W-1:0] golden(input int k);
    logic [W-1:0] s = SEED;
    for (int i = 0; i < k; i++) s = rule30(s);
    return s;
  endfunction

  // CA model driven only by the DUT controls
  always @(posedge Clk_CI)
    if (Reset_RI || CaClear_SO) CaValue_DI <= SEED;
    else if (CaEnable_SO) CaValue_DI <= rule30(CaValue_DI);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input string name, input int idx, input int lat, input int en,
                         input int clr, input bit err, input int steps, input int hold);
    int cyc = 0, ne = 0, nc = 0, both = 0;
    logic [W-1:0] hv;
    logic e;
    @(negedge Clk_CI);
    chk({name, " ready"}, W'(ReqReady_SO), W'(1));
    HvReady_SI  = (hold == 0);
    ReqValid_SI = 1'b1;
    ReqIdx_DI   = (IW+1)'(idx);
    @(negedge Clk_CI);
    ReqValid_SI = 1'b0;
    ReqIdx_DI   = ~ReqIdx_DI;
    while (1) begin
      cyc++;
      ne += int'(CaEnable_SO);
      nc += int'(CaClear_SO);
      both += int'(CaEnable_SO & CaClear_SO);
      if (HvValid_SO || cyc > 200) break;
      @(negedge Clk_CI);
    end
    chk({name, " latency"}, W'(cyc), W'(lat));
    chk({name, " enables"}, W'(ne), W'(en));
    chk({name, " clears"}, W'(nc), W'(clr));
    chk({name, " overlap"}, W'(both), W'(0));
    chk({name, " err"}, W'(Err_SO), W'(err));
    chk({name, " hv"}, Hv_DO, err ? '0 : golden(steps));
    if (hold > 0) begin
      hv = Hv_DO;
      e  = Err_SO;
      for (int i = 0; i < hold; i++) begin
        @(negedge Clk_CI);
        if (!HvValid_SO || Hv_DO !== hv || Err_SO !== e || ReqReady_SO || CaEnable_SO || CaClear_SO) both++;
      end
      chk({name, " hold stable"}, W'(both), W'(0));
      HvReady_SI = 1'b1;
    end
    @(negedge Clk_CI);
    chk({name, " valid drop"}, W'(HvValid_SO), W'(0));
  endtask

  typedef struct {
    string name;
    int    idx;
    int    lat;
    int    en;
    int    clr;
    bit    err;
    int    steps;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"idx0 seed",   0,  2,  0, 0, 1'b0, 0};
    vecs[1] = '{"idx5 fwd",    5,  7,  5, 0, 1'b0, 5};
    vecs[2] = '{"idx8 fwd",    8,  5,  3, 0, 1'b0, 8};
    vecs[3] = '{"idx8 hit",    8,  2,  0, 0, 1'b0, 8};
    vecs[4] = '{"idx2 back",   2,  5,  2, 1, 1'b0, 2};
    vecs[5] = '{"idx64 oor",   64, 1,  0, 0, 1'b1, 0};
    vecs[6] = '{"idx2 hit",    2,  2,  0, 0, 1'b0, 2};
    vecs[7] = '{"idx63 fwd",   63, 63, 61, 0, 1'b0, 63};
    vecs[8] = '{"idx127 oor",  127, 1, 0, 0, 1'b1, 0};
    vecs[9] = '{"idx0 back",   0,  3,  0, 1, 1'b0, 0};

    repeat (3) @(negedge Clk_CI);
    chk("rst ready", W'(ReqReady_SO), W'(0));
    chk("rst valid", W'(HvValid_SO), W'(0));
    chk("rst hv", Hv_DO, '0);
    chk("rst err", W'(Err_SO), W'(0));
    chk("rst ctrl", W'({CaClear_SO, CaEnable_SO}), W'(0));
    Reset_RI = 1'b0;

    for (int i = 0; i < 10; i++)
      run_req(vecs[i].name, vecs[i].idx, vecs[i].lat, vecs[i].en, vecs[i].clr, vecs[i].err, vecs[i].steps, 0);

    run_req("idx10 hold", 10, 12, 10, 0, 1'b0, 10, 20);

    @(negedge Clk_CI);
    HvReady_SI  = 1'b1;
    ReqValid_SI = 1'b1;
    ReqIdx_DI   = (IW+1)'(20);
    @(negedge Clk_CI);
    ReqValid_SI = 1'b0;
    @(negedge Clk_CI);
    chk("mid step enable", W'(CaEnable_SO), W'(1));
    Reset_RI = 1'b1;
    @(negedge Clk_CI);
    chk("mid rst valid", W'(HvValid_SO), W'(0));
    chk("mid rst ctrl", W'({CaClear_SO, CaEnable_SO}), W'(0));
    chk("mid rst hv", Hv_DO, '0);
    chk("mid rst err", W'(Err_SO), W'(0));
    chk("mid rst ready", W'(ReqReady_SO), W'(0));
    Reset_RI = 1'b0;
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge Clk_CI);
        seen += int'(HvValid_SO | CaEnable_SO | CaClear_SO);
      end
      chk("no response after rst", W'(seen), W'(0));
    end
    run_req("idx0 after rst", 0, 2, 0, 0, 1'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
